// File: rtl/wb_stage.sv
// Writeback stage: commits ALU/MEM slot results into the 8x32 register file,
// commits ALU flags, serves four bypassed read ports and counts retired writes.
module wb_stage #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p4_alu_we,
    input  logic [$clog2(NREGS)-1:0] p4_alu_rd,
    input  logic [DW-1:0]            p4_alu_aluOut,
    input  logic                     p4_mem_we,
    input  logic [$clog2(NREGS)-1:0] p4_mem_rd,
    input  logic [DW-1:0]            p4_mem_memOut,
    input  logic                     p4_flag_we,
    input  logic                     p4_flag_z,
    input  logic                     p4_flag_n,
    input  logic                     p4_flag_c,
    input  logic                     p4_flag_v,
    input  logic [$clog2(NREGS)-1:0] rd_addr0,
    input  logic [$clog2(NREGS)-1:0] rd_addr1,
    input  logic [$clog2(NREGS)-1:0] rd_addr2,
    input  logic [$clog2(NREGS)-1:0] rd_addr3,
    output logic [DW-1:0]            rd_data0,
    output logic [DW-1:0]            rd_data1,
    output logic [DW-1:0]            rd_data2,
    output logic [DW-1:0]            rd_data3,
    output logic                     flag_z,
    output logic                     flag_n,
    output logic                     flag_c,
    output logic                     flag_v,
    output logic [31:0]              retired_count
);

    localparam int unsigned AW     = $clog2(NREGS);
    localparam int unsigned CW     = 32;
    localparam int unsigned NPORTS = 4;

    logic [DW-1:0] regs [NREGS];
    logic [3:0]    flag_q;
    logic          alu_commit;
    logic [1:0]    n_writes;
    logic [AW-1:0] rd_addr [NPORTS];
    logic [DW-1:0] rd_data [NPORTS];

    // MEM slot wins a same-destination conflict, so the ALU write is dropped
    always_comb begin
        alu_commit = p4_alu_we && !(p4_mem_we && (p4_alu_rd == p4_mem_rd));
        n_writes   = 2'(alu_commit) + 2'(p4_mem_we);
    end

    // Register file commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (alu_commit) begin
                regs[p4_alu_rd] <= p4_alu_aluOut;
            end
            if (p4_mem_we) begin
                regs[p4_mem_rd] <= p4_mem_memOut;
            end
        end
    end

    // Flag register {z,n,c,v}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= '0;
        end else if (p4_flag_we) begin
            flag_q <= {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v};
        end
    end

    // Retired-write counter, wraps modulo 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
        end else begin
            retired_count <= retired_count + CW'(n_writes);
        end
    end

    assign rd_addr[0] = rd_addr0;
    assign rd_addr[1] = rd_addr1;
    assign rd_addr[2] = rd_addr2;
    assign rd_addr[3] = rd_addr3;

    // Read ports: MEM bypass, then ALU bypass, then register file
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            rd_data[p] = regs[rd_addr[p]];
            if (p4_mem_we && (p4_mem_rd == rd_addr[p])) begin
                rd_data[p] = p4_mem_memOut;
            end else if (p4_alu_we && (p4_alu_rd == rd_addr[p])) begin
                rd_data[p] = p4_alu_aluOut;
            end
        end
    end

    assign rd_data0 = rd_data[0];
    assign rd_data1 = rd_data[1];
    assign rd_data2 = rd_data[2];
    assign rd_data3 = rd_data[3];

    // Flag outputs bypass the incoming flags during a flag write
    always_comb begin
        {flag_z, flag_n, flag_c, flag_v} = flag_q;
        if (p4_flag_we) begin
            {flag_z, flag_n, flag_c, flag_v} = {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v};
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// checked against a behavioural register-file model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        p4_alu_we, p4_mem_we, p4_flag_we;
    logic [2:0]  p4_alu_rd, p4_mem_rd;
    logic [31:0] p4_alu_aluOut, p4_mem_memOut;
    logic        p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v;
    logic [2:0]  ra [4];
    logic [31:0] rdo [4];
    logic        flag_z, flag_n, flag_c, flag_v;
    logic [31:0] retired_count;

    wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .p4_alu_we     (p4_alu_we),
        .p4_alu_rd     (p4_alu_rd),
        .p4_alu_aluOut (p4_alu_aluOut),
        .p4_mem_we     (p4_mem_we),
        .p4_mem_rd     (p4_mem_rd),
        .p4_mem_memOut (p4_mem_memOut),
        .p4_flag_we    (p4_flag_we),
        .p4_flag_z     (p4_flag_z),
        .p4_flag_n     (p4_flag_n),
        .p4_flag_c     (p4_flag_c),
        .p4_flag_v     (p4_flag_v),
        .rd_addr0      (ra[0]),
        .rd_addr1      (ra[1]),
        .rd_addr2      (ra[2]),
        .rd_addr3      (ra[3]),
        .rd_data0      (rdo[0]),
        .rd_data1      (rdo[1]),
        .rd_data2      (rdo[2]),
        .rd_data3      (rdo[3]),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] model_regs [8];
    logic [3:0]  model_flags;
    logic [31:0] model_count;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural view once this cycle's writes land; later write (MEM) overrides
    function automatic logic [31:0] exp_read(input logic [2:0] a);
        logic [31:0] pending [8];
        pending = model_regs;
        if (p4_alu_we) pending[p4_alu_rd] = p4_alu_aluOut;
        if (p4_mem_we) pending[p4_mem_rd] = p4_mem_memOut;
        return pending[a];
    endfunction

    function automatic logic [3:0] exp_flags();
        return p4_flag_we ? {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v} : model_flags;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        model_flags = '0;
        model_count = '0;
    endtask

    task automatic model_commit();
        logic [31:0] nxt [8];
        bit          touched [8];
        int          n;
        if (reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < 8; i++) begin
                nxt[i]     = exp_read(3'(i));
                touched[i] = 1'b0;
            end
            if (p4_alu_we) touched[p4_alu_rd] = 1'b1;
            if (p4_mem_we) touched[p4_mem_rd] = 1'b1;
            n = 0;
            for (int i = 0; i < 8; i++) if (touched[i]) n++;
            model_regs  = nxt;
            model_flags = exp_flags();
            model_count = model_count + 32'(n);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s rd_data%0d", tag, i), rdo[i], exp_read(ra[i]));
        end
        check({tag, " flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(exp_flags()));
        check({tag, " retired_count"}, retired_count, model_count);
    endtask

    // Inputs are set shortly after a rising edge; check mid-cycle, then step the edge
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        p4_alu_we  = 1'b0;
        p4_mem_we  = 1'b0;
        p4_flag_we = 1'b0;
    endtask

    task automatic set_alu(input logic [2:0] rd, input logic [31:0] d);
        p4_alu_we = 1'b1; p4_alu_rd = rd; p4_alu_aluOut = d;
    endtask

    task automatic set_mem(input logic [2:0] rd, input logic [31:0] d);
        p4_mem_we = 1'b1; p4_mem_rd = rd; p4_mem_memOut = d;
    endtask

    task automatic set_reads(input logic [2:0] a0, input logic [2:0] a1,
                             input logic [2:0] a2, input logic [2:0] a3);
        ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
    endtask

    task automatic set_flags(input logic we, input logic [3:0] f);
        p4_flag_we = we;
        {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v} = f;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        idle();
        p4_alu_rd = '0; p4_alu_aluOut = '0; p4_mem_rd = '0; p4_mem_memOut = '0;
        set_flags(1'b0, 4'b0000);
        set_reads(3'd3, 3'd0, 3'd3, 3'd7);

        // Writes attempted under reset are discarded
        set_alu(3'd3, 32'hCAFE0001);
        set_mem(3'd3, 32'h00000077);
        set_flags(1'b1, 4'b1111);
        cycle("reset_wr");
        idle();
        set_flags(1'b0, 4'b0000);
        #1;
        check("reset r3", rdo[0], 32'h0);
        check("reset flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h0);
        check("reset count", retired_count, 32'h0);
        cycle("reset_hold");
        reset = 1'b0;

        // Dual write, distinct destinations
        set_alu(3'd2, 32'h11111111);
        set_mem(3'd5, 32'h000000AB);
        set_reads(3'd2, 3'd5, 3'd0, 3'd7);
        #1;
        check("dual bypass r2", rdo[0], 32'h11111111);
        check("dual bypass r5", rdo[1], 32'h000000AB);
        cycle("dual_wr");
        idle();
        #1;
        check("dual reg r2", rdo[0], 32'h11111111);
        check("dual reg r5", rdo[1], 32'h000000AB);
        check("dual count", retired_count, 32'd2);
        cycle("dual_rd");

        // Same-destination conflict: MEM wins, one retired write
        set_alu(3'd4, 32'hDEADBEEF);
        set_mem(3'd4, 32'h00000042);
        set_reads(3'd4, 3'd4, 3'd2, 3'd4);
        #1;
        check("conflict bypass r4", rdo[0], 32'h00000042);
        cycle("conflict_wr");
        idle();
        #1;
        check("conflict reg r4", rdo[0], 32'h00000042);
        check("conflict count", retired_count, 32'd3);
        cycle("conflict_rd");

        // Flags load 1010, then hold while inputs toggle
        set_flags(1'b1, 4'b1010);
        #1;
        check("flag bypass", 32'({flag_z, flag_n, flag_c, flag_v}), 32'hA);
        cycle("flag_wr");
        set_flags(1'b0, 4'b0101);
        cycle("flag_hold1");
        set_flags(1'b0, 4'b1111);
        #1;
        check("flag hold", 32'({flag_z, flag_n, flag_c, flag_v}), 32'hA);
        cycle("flag_hold2");

        // Counter wrap: preload to 0xFFFFFFFE, then one dual write
        @(negedge clk);
        force dut.retired_count = 32'hFFFFFFFE;
        #1;
        release dut.retired_count;
        model_count = 32'hFFFFFFFE;
        set_alu(3'd0, 32'h0000000F);
        set_mem(3'd6, 32'h00000060);
        set_reads(3'd0, 3'd6, 3'd1, 3'd2);
        cycle("wrap_wr");
        idle();
        #1;
        check("wrap count", retired_count, 32'h0);
        cycle("wrap_rd");

        // Async reset between edges clears r1 immediately
        set_alu(3'd1, 32'h00000005);
        set_reads(3'd1, 3'd2, 3'd5, 3'd0);
        cycle("r1_wr");
        idle();
        #1;
        check("r1 before reset", rdo[0], 32'h5);
        reset = 1'b1;
        #1;
        check("async reset r1", rdo[0], 32'h0);
        check("async reset r2", rdo[1], 32'h0);
        check("async reset flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h0);
        check("async reset count", retired_count, 32'h0);
        model_clear();
        reset = 1'b0;
        cycle("post_reset");

        // Randomized traffic, biased toward collisions on a small register set
        for (int it = 0; it < 400; it++) begin
            p4_alu_we     = ($urandom_range(0, 3) != 0);
            p4_alu_rd     = 3'($urandom_range(0, 7));
            p4_alu_aluOut = $urandom();
            p4_mem_we     = ($urandom_range(0, 2) != 0);
            p4_mem_rd     = ($urandom_range(0, 3) == 0) ? p4_alu_rd : 3'($urandom_range(0, 7));
            p4_mem_memOut = $urandom();
            set_flags(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            for (int p = 0; p < 4; p++) ra[p] = 3'($urandom_range(0, 7));
            cycle($sformatf("rand%0d", it));
        end

        idle();
        cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
